// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the FSM state encodings, the response error code, the default geometry
// and latency, and the address-decode helper used by the top level.
package data_mem_responder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

    localparam int unsigned DEFAULT_DEPTH_WORDS = 512;
    localparam int unsigned DEFAULT_ADDR_W      = 9;
    localparam int unsigned DEFAULT_LATENCY     = 2;

    // LATENCY is limited to 0..15, so a 4-bit countdown suffices.
    localparam int unsigned LAT_CNT_W = 4;

    // A request errors when it is not word aligned or when any byte-address bit
    // above the word index is set (no wrap-around into the RAM).
    function automatic logic addr_is_bad(input logic [31:0] addr, input int unsigned addr_w);
        logic [31:0] upper;
        upper = addr >> (addr_w + 2);
        return (addr[1:0] != 2'b00) || (upper != '0);
    endfunction

endpackage

// File: rtl/data_mem_responder_mem_wait_counter.sv
// Wait-state countdown for the data-memory responder.
// Ports:
//   clk      in  rising-edge clock
//   rst_n    in  asynchronous active-low reset (count cleared to 0)
//   load     in  load load_val (takes priority over dec)
//   load_val in  initial countdown value
//   dec      in  decrement by one, saturating at zero
//   zero     out count is zero
module mem_wait_counter
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned CNT_W = LAT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory port: word-addressed 32-bit RAM behind a
// valid/ready request channel and a valid/ready response channel, one
// transaction outstanding at a time, with LATENCY configurable wait states.
// Ports:
//   clk       in   rising-edge clock
//   Reset     in   asynchronous active-low reset
//   req_valid in   request present
//   req_ready out  responder idle and able to accept
//   req_write in   1 = store, 0 = load
//   req_addr  in   byte address
//   req_wdata in   store data
//   rsp_valid out  response available
//   rsp_ready in   response accepted
//   rsp_rdata out  load data (0 for stores and errors)
//   rsp_err   out  misaligned or out-of-range address
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD =
        (LATENCY == 0) ? '0 : LAT_CNT_W'(LATENCY - 1);

    logic [31:0] mem [DEPTH_WORDS];

    logic [1:0]        state_q, state_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q,   err_d;

    logic              accept;
    logic              req_err;
    logic [ADDR_W-1:0] word_idx;
    logic              mem_we;
    logic              cnt_zero;

    // Gated with Reset so the CPU sees no ready while reset is held, even
    // though the state register already reads IDLE.
    assign req_ready = (state_q == ST_IDLE) && Reset;
    assign accept    = req_valid && req_ready;
    assign req_err   = addr_is_bad(req_addr, ADDR_W);
    assign word_idx  = req_addr[ADDR_W+1:2];
    assign mem_we    = accept && req_write && !req_err;

    mem_wait_counter #(
        .CNT_W (LAT_CNT_W)
    ) u_wait_cnt (
        .clk      (clk),
        .rst_n    (Reset),
        .load     (accept),
        .load_val (LAT_LOAD),
        .dec      (state_q == ST_WAIT),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    err_d   = req_err ? RSP_ERR : RSP_OK;
                    rdata_d = (!req_write && !req_err) ? mem[word_idx] : '0;
                    state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM contents survive reset, so the array sits outside the reset block.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= req_wdata;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance and a LATENCY=0
// instance share stimulus; sel chooses which one receives requests and is observed.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        Reset;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        rr2, rv2, re2, rr0, rv0, re0;
    logic [31:0] rd2, rd0;

    logic        o_req_ready, o_rsp_valid, o_rsp_err;
    logic [31:0] o_rsp_rdata;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_WORDS (512),
        .ADDR_W      (9),
        .LATENCY     (2)
    ) u_dut (
        .clk       (clk),
        .Reset     (Reset),
        .req_valid (req_valid && !sel),
        .req_ready (rr2),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rv2),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rd2),
        .rsp_err   (re2)
    );

    data_mem_responder #(
        .DEPTH_WORDS (512),
        .ADDR_W      (9),
        .LATENCY     (0)
    ) u_dut_lat0 (
        .clk       (clk),
        .Reset     (Reset),
        .req_valid (req_valid && sel),
        .req_ready (rr0),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rv0),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rd0),
        .rsp_err   (re0)
    );

    assign o_req_ready = sel ? rr0 : rr2;
    assign o_rsp_valid = sel ? rv0 : rv2;
    assign o_rsp_rdata = sel ? rd0 : rd2;
    assign o_rsp_err   = sel ? re0 : re2;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
    task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input int unsigned lat, input int unsigned hold,
                       input logic [31:0] exp_rd, input logic exp_err);
        int unsigned waits;
        int unsigned n;
        logic        acc;
        logic [31:0] first_rd;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        acc = 1'b0;
        for (waits = 0; waits < 20; waits++) begin
            acc = o_req_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) break;
        end
        req_valid = 1'b0;
        check_val({tag, "_accept"}, 32'(acc), 32'd1);
        check_val({tag, "_accept_wait"}, waits, 32'd0);
        if (!acc) return;
        n = 1;
        while (!o_rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_latency"}, n, lat + 1);
        check_val({tag, "_rdata"}, o_rsp_rdata, exp_rd);
        check_val({tag, "_err"}, 32'(o_rsp_err), 32'(exp_err));
        check_val({tag, "_ready_in_resp"}, 32'(o_req_ready), 32'd0);
        first_rd = o_rsp_rdata;
        for (int unsigned k = 0; k < hold; k++) begin
            check_val({tag, "_hold_valid"}, 32'(o_rsp_valid), 32'd1);
            check_val({tag, "_hold_rdata"}, o_rsp_rdata, first_rd);
            check_val({tag, "_hold_ready"}, 32'(o_req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check_val({tag, "_valid_drop"}, 32'(o_rsp_valid), 32'd0);
    endtask

    initial begin
        Reset     = 1'b0;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        check_val("rst_req_ready", 32'(o_req_ready), 32'd0);
        check_val("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check_val("rst_rsp_rdata", o_rsp_rdata, 32'd0);
        check_val("rst_rsp_err", 32'(o_rsp_err), 32'd0);
        Reset = 1'b1;
        @(negedge clk);
        check_val("post_rst_ready", 32'(o_req_ready), 32'd1);

        // Reset mid-WAIT drops the load of 0x10 without a response.
        req_write = 1'b0;
        req_addr  = 32'h10;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_val("wait_no_valid", 32'(o_rsp_valid), 32'd0);
        Reset = 1'b0;
        #1;
        check_val("inrst_ready", 32'(o_req_ready), 32'd0);
        check_val("inrst_valid", 32'(o_rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        check_val("inrst_ready2", 32'(o_req_ready), 32'd0);
        check_val("inrst_valid2", 32'(o_rsp_valid), 32'd0);
        Reset = 1'b1;
        @(negedge clk);
        check_val("rel_ready", 32'(o_req_ready), 32'd1);
        for (int unsigned i = 0; i < 5; i++) begin
            check_val("rel_no_rsp", 32'(o_rsp_valid), 32'd0);
            @(negedge clk);
        end

        // Boundary words.
        txn("sw_w0",   1'b1, 32'h0,   32'h1111_1111, 2, 0, 32'h0,         1'b0);
        txn("sw_wlst", 1'b1, 32'h7FC, 32'hA5A5_5A5A, 2, 0, 32'h0,         1'b0);
        txn("lw_w0",   1'b0, 32'h0,   32'h0,         2, 0, 32'h1111_1111, 1'b0);
        txn("lw_wlst", 1'b0, 32'h7FC, 32'h0,         2, 0, 32'hA5A5_5A5A, 1'b0);

        // Store then load.
        txn("sw_20", 1'b1, 32'h20, 32'hDEAD_BEEF, 2, 0, 32'h0,         1'b0);
        txn("lw_20", 1'b0, 32'h20, 32'h0,         2, 0, 32'hDEAD_BEEF, 1'b0);

        // Backpressure for 5 cycles.
        txn("lw_bp", 1'b0, 32'h20, 32'h0, 2, 5, 32'hDEAD_BEEF, 1'b0);

        // Errors: misaligned, out of range, and no RAM side effect.
        txn("lw_mis", 1'b0, 32'h22,  32'h0,         2, 0, 32'h0,         1'b1);
        txn("sw_oor", 1'b1, 32'h800, 32'hFFFF_FFFF, 2, 0, 32'h0,         1'b1);
        txn("lw_0ok", 1'b0, 32'h0,   32'h0,         2, 0, 32'h1111_1111, 1'b0);
        txn("sw_mis", 1'b1, 32'h21,  32'h0BAD_0BAD, 2, 0, 32'h0,         1'b1);
        txn("lw_20b", 1'b0, 32'h20,  32'h0,         2, 0, 32'hDEAD_BEEF, 1'b0);
        txn("lw_hi",  1'b0, 32'h8000_0000, 32'h0,   2, 0, 32'h0,         1'b1);

        // LATENCY=0 instance: back-to-back, accepted on consecutive 2-cycle slots.
        sel = 1'b1;
        @(negedge clk);
        txn("l0_sw40", 1'b1, 32'h40,  32'h1234_5678, 0, 0, 32'h0,         1'b0);
        txn("l0_sw44", 1'b1, 32'h44,  32'hCAFE_F00D, 0, 0, 32'h0,         1'b0);
        txn("l0_lw40", 1'b0, 32'h40,  32'h0,         0, 0, 32'h1234_5678, 1'b0);
        txn("l0_lw44", 1'b0, 32'h44,  32'h0,         0, 0, 32'hCAFE_F00D, 1'b0);
        txn("l0_oor",  1'b0, 32'h804, 32'h0,         0, 0, 32'h0,         1'b1);
        txn("l0_bp",   1'b0, 32'h44,  32'h0,         0, 3, 32'hCAFE_F00D, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
